// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl: RV32I-subset multi-cycle control FSM (optional PERF_CNT_EN)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     Instr_i,
  input  logic            Zero_i,
  input  logic            ICache_stall_i,
  input  logic            DCache_stall_i,
  output logic            ICache_ren_o,
  output logic            DCache_ren_o,
  output logic            DCache_wen_o,
  output logic            IR_write_o,
  output logic            PC_write_o,
  output logic [1:0]      PC_sel_o,
  output logic            ALUSrcB_o,
  output logic [3:0]      ALUCtrl_o,
  output logic            RegWrite_o,
  output logic [1:0]      WBSel_o,
  output logic            Trap_o,
  output logic [XLEN-1:0] Cycle_cnt_o,
  output logic [XLEN-1:0] Retire_cnt_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  localparam logic [1:0] PCS_PC4 = 2'b00;
  localparam logic [1:0] PCS_IMM = 2'b01;
  localparam logic [1:0] PCS_REG = 2'b10;

  localparam logic [1:0] WBS_ALU = 2'b00;
  localparam logic [1:0] WBS_MEM = 2'b01;
  localparam logic [1:0] WBS_PC4 = 2'b10;

  state_t state, state_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rd;
  logic       unused_instr_bits;

  assign opcode            = Instr_i[6:0];
  assign rd                = Instr_i[11:7];
  assign funct3            = Instr_i[14:12];
  assign funct7_b5         = Instr_i[30];
  assign unused_instr_bits = ^{Instr_i[31], Instr_i[29:15]};

  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, legal, br_taken;
  logic [3:0] alu_op;

  assign is_r    = (opcode == OP_R);
  assign is_i    = (opcode == OP_I);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_br   = (opcode == OP_BR);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  // Only BEQ (000) and BNE (001) are supported branches.
  assign legal   = is_r | is_i | is_lw | is_sw | is_jal | is_jalr |
                   (is_br && (funct3[2:1] == 2'b00));
  assign br_taken = funct3[0] ? !Zero_i : Zero_i;

  // funct7[5] only selects SUB for register-register adds; ADDI ignores it.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b100:  alu_op = ALU_XOR;
      3'b010:  alu_op = ALU_SLT;
      3'b001:  alu_op = ALU_SLL;
      3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
      default: alu_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    ICache_ren_o = 1'b0;
    DCache_ren_o = 1'b0;
    DCache_wen_o = 1'b0;
    IR_write_o   = 1'b0;
    PC_write_o   = 1'b0;
    PC_sel_o     = PCS_PC4;
    ALUSrcB_o    = 1'b0;
    ALUCtrl_o    = ALU_ADD;
    RegWrite_o   = 1'b0;
    WBSel_o      = WBS_ALU;
    Trap_o       = 1'b0;
    // While reset is held every output stays quiet, including the fetch request.
    if (rst_n) begin
      case (state)
        FETCH: begin
          ICache_ren_o = 1'b1;
          if (!ICache_stall_i) begin
            IR_write_o = 1'b1;
            state_next = DECODE;
          end
        end
        DECODE: state_next = legal ? EXEC : TRAP;
        EXEC: begin
          state_next = WB;
          if (is_r) begin
            ALUCtrl_o = alu_op;
          end else if (is_i) begin
            ALUSrcB_o = 1'b1;
            ALUCtrl_o = alu_op;
          end else if (is_lw || is_sw) begin
            ALUSrcB_o  = 1'b1;
            state_next = MEM;
          end else if (is_br) begin
            ALUCtrl_o  = ALU_SUB;
            PC_write_o = 1'b1;
            PC_sel_o   = br_taken ? PCS_IMM : PCS_PC4;
            state_next = FETCH;
          end else if (is_jal) begin
            PC_sel_o = PCS_IMM;
          end else if (is_jalr) begin
            ALUSrcB_o = 1'b1;
            PC_sel_o  = PCS_REG;
          end else begin
            state_next = TRAP;
          end
        end
        MEM: begin
          DCache_ren_o = is_lw;
          DCache_wen_o = !is_lw;
          if (!DCache_stall_i) begin
            if (is_lw) begin
              state_next = WB;
            end else begin
              PC_write_o = 1'b1;
              state_next = FETCH;
            end
          end
        end
        WB: begin
          RegWrite_o = (rd != 5'd0);
          if (is_lw)                 WBSel_o = WBS_MEM;
          else if (is_jal || is_jalr) WBSel_o = WBS_PC4;
          PC_write_o = 1'b1;
          if (is_jal)       PC_sel_o = PCS_IMM;
          else if (is_jalr) PC_sel_o = PCS_REG;
          state_next = FETCH;
        end
        TRAP: Trap_o = 1'b1;
        default: state_next = FETCH;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [XLEN-1:0] cycle_cnt;
  logic [XLEN-1:0] retire_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + XLEN'(1);
      if (PC_write_o) retire_cnt <= retire_cnt + XLEN'(1);
    end
  end

  assign Cycle_cnt_o  = cycle_cnt;
  assign Retire_cnt_o = retire_cnt;
`else
  assign Cycle_cnt_o  = '0;
  assign Retire_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     Instr_i;
  logic            Zero_i;
  logic            ICache_stall_i;
  logic            DCache_stall_i;
  logic            ICache_ren_o, DCache_ren_o, DCache_wen_o, IR_write_o, PC_write_o;
  logic [1:0]      PC_sel_o;
  logic            ALUSrcB_o;
  logic [3:0]      ALUCtrl_o;
  logic            RegWrite_o;
  logic [1:0]      WBSel_o;
  logic            Trap_o;
  logic [XLEN-1:0] Cycle_cnt_o, Retire_cnt_o;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .Instr_i(Instr_i), .Zero_i(Zero_i),
    .ICache_stall_i(ICache_stall_i), .DCache_stall_i(DCache_stall_i),
    .ICache_ren_o(ICache_ren_o), .DCache_ren_o(DCache_ren_o), .DCache_wen_o(DCache_wen_o),
    .IR_write_o(IR_write_o), .PC_write_o(PC_write_o), .PC_sel_o(PC_sel_o),
    .ALUSrcB_o(ALUSrcB_o), .ALUCtrl_o(ALUCtrl_o), .RegWrite_o(RegWrite_o),
    .WBSel_o(WBSel_o), .Trap_o(Trap_o), .Cycle_cnt_o(Cycle_cnt_o), .Retire_cnt_o(Retire_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // {icr, dcr, dcw, irw, pcw, pc_sel[1:0], srcb, alu[3:0], rw, wbsel[1:0], trap}
  logic [15:0] outs;
  assign outs = {ICache_ren_o, DCache_ren_o, DCache_wen_o, IR_write_o, PC_write_o, PC_sel_o,
                 ALUSrcB_o, ALUCtrl_o, RegWrite_o, WBSel_o, Trap_o};

  function automatic logic [15:0] ov(input int icr, input int dcr, input int dcw, input int irw,
                                     input int pcw, input int pcs, input int sb, input int alu,
                                     input int rw, input int wbs, input int tr);
    return {1'(icr), 1'(dcr), 1'(dcw), 1'(irw), 1'(pcw), 2'(pcs), 1'(sb), 4'(alu),
            1'(rw), 2'(wbs), 1'(tr)};
  endfunction

  // Leaves the bench 1 time unit after the releasing edge: the first FETCH cycle.
  task automatic do_reset(input logic [31:0] instr);
    rst_n = 1'b0; Instr_i = instr; Zero_i = 1'b0;
    ICache_stall_i = 1'b0; DCache_stall_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; Instr_i = 32'h0050_0093; Zero_i = 1'b0;
    ICache_stall_i = 1'b0; DCache_stall_i = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (outs !== 16'h0) begin
      failures++; $display("FAIL reset_outs got=%h exp=%h", outs, 16'h0);
    end
    checks++;
    if ({Cycle_cnt_o, Retire_cnt_o} !== '0) begin
      failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", Cycle_cnt_o, Retire_cnt_o);
    end
    tick;
    rst_n = 1'b1;
    ICache_stall_i = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== ov(1,0,0,0,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL reset_fetch got=%h exp=%h", outs, ov(1,0,0,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_fetch_stall;
    logic [15:0] e [5];
    logic        st [5];
    e  = '{ov(1,0,0,0,0,0,0,0,0,0,0), ov(1,0,0,0,0,0,0,0,0,0,0), ov(1,0,0,1,0,0,0,0,0,0,0),
           ov(0,0,0,0,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,1,0,0,0,0)};
    st = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset(32'h0050_0093);
    for (int c = 0; c < 5; c++) begin
      ICache_stall_i = st[c];
      @(negedge clk);
      checks++;
      if (outs !== e[c]) begin
        failures++; $display("FAIL fetch_stall cyc%0d got=%h exp=%h", c + 1, outs, e[c]);
      end
      tick;
    end
  endtask

  task automatic test_alu;
    logic [31:0] ins [9];
    logic [3:0]  alu [9];
    logic        sb  [9];
    logic [15:0] e   [5];
    ins = '{32'h0050_0093, 32'h4020_81B3, 32'h4030_D093, 32'h4000_0093, 32'h0020_F1B3,
            32'h0020_D1B3, 32'h0020_91B3, 32'h0040_C093, 32'h0050_A093};
    alu = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5};
    sb  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 9; k++) begin
      e = '{ov(1,0,0,1,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0,0,0),
            ov(0,0,0,0,0,0,int'(sb[k]),int'(alu[k]),0,0,0),
            ov(0,0,0,0,1,0,0,0,1,0,0), ov(1,0,0,1,0,0,0,0,0,0,0)};
      do_reset(ins[k]);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        checks++;
        if (outs !== e[c]) begin
          failures++; $display("FAIL alu_%0d cyc%0d got=%h exp=%h", k, c + 1, outs, e[c]);
        end
        tick;
      end
    end
  endtask

  task automatic test_load_stall;
    logic [15:0] e  [9];
    logic        st [9];
    e = '{ov(1,0,0,1,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,1,0,0,0,0),
          ov(0,1,0,0,0,0,0,0,0,0,0), ov(0,1,0,0,0,0,0,0,0,0,0), ov(0,1,0,0,0,0,0,0,0,0,0),
          ov(0,1,0,0,0,0,0,0,0,0,0), ov(0,0,0,0,1,0,0,0,1,1,0), ov(1,0,0,1,0,0,0,0,0,0,0)};
    st = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset(32'h0000_A103);
    for (int c = 0; c < 9; c++) begin
      DCache_stall_i = st[c];
      @(negedge clk);
      checks++;
      if (outs !== e[c]) begin
        failures++; $display("FAIL lw_stall cyc%0d got=%h exp=%h", c + 1, outs, e[c]);
      end
      tick;
    end
  endtask

  task automatic test_store;
    logic [15:0] e [5];
    e = '{ov(1,0,0,1,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,1,0,0,0,0),
          ov(0,0,1,0,1,0,0,0,0,0,0), ov(1,0,0,1,0,0,0,0,0,0,0)};
    do_reset(32'h0020_A023);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (outs !== e[c]) begin
        failures++; $display("FAIL sw cyc%0d got=%h exp=%h", c + 1, outs, e[c]);
      end
      tick;
    end
  endtask

  task automatic test_branch;
    logic [31:0] ins [4];
    logic        z   [4];
    int          pcs [4];
    logic [15:0] e   [4];
    ins = '{32'h0020_9463, 32'h0020_8463, 32'h0020_8463, 32'h0020_9463};
    z   = '{1'b0, 1'b0, 1'b1, 1'b1};
    pcs = '{1, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      e = '{ov(1,0,0,1,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0,0,0),
            ov(0,0,0,0,1,pcs[k],0,1,0,0,0), ov(1,0,0,1,0,0,0,0,0,0,0)};
      do_reset(ins[k]);
      Zero_i = z[k];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (outs !== e[c]) begin
          failures++; $display("FAIL branch_%0d cyc%0d got=%h exp=%h", k, c + 1, outs, e[c]);
        end
        tick;
      end
    end
  endtask

  task automatic test_jump;
    logic [31:0] ins [2];
    logic [15:0] ex  [2];
    logic [15:0] wb  [2];
    logic [15:0] e   [5];
    ins = '{32'h0000_006F, 32'h0001_00E7};
    ex  = '{ov(0,0,0,0,0,1,0,0,0,0,0), ov(0,0,0,0,0,2,1,0,0,0,0)};
    wb  = '{ov(0,0,0,0,1,1,0,0,0,2,0), ov(0,0,0,0,1,2,0,0,1,2,0)};
    for (int k = 0; k < 2; k++) begin
      e = '{ov(1,0,0,1,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0,0,0), ex[k], wb[k],
            ov(1,0,0,1,0,0,0,0,0,0,0)};
      do_reset(ins[k]);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        checks++;
        if (outs !== e[c]) begin
          failures++; $display("FAIL jump_%0d cyc%0d got=%h exp=%h", k, c + 1, outs, e[c]);
        end
        tick;
      end
    end
  endtask

  task automatic test_trap;
    logic [31:0] ins [2];
    logic [15:0] e   [6];
    ins = '{32'h0000_007F, 32'h0020_C463};
    e = '{ov(1,0,0,1,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0,0,1),
          ov(0,0,0,0,0,0,0,0,0,0,1), ov(0,0,0,0,0,0,0,0,0,0,1), ov(0,0,0,0,0,0,0,0,0,0,1)};
    for (int k = 0; k < 2; k++) begin
      do_reset(ins[k]);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        checks++;
        if (outs !== e[c]) begin
          failures++; $display("FAIL trap_%0d cyc%0d got=%h exp=%h", k, c + 1, outs, e[c]);
        end
        tick;
      end
    end
  endtask

  task automatic test_reset_in_mem;
    do_reset(32'h0000_A103);
    DCache_stall_i = 1'b1;
    tick; tick; tick;
    @(negedge clk);
    checks++;
    if (outs !== ov(0,1,0,0,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL mem_before_rst got=%h exp=%h", outs, ov(0,1,0,0,0,0,0,0,0,0,0));
    end
    #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (outs !== 16'h0) begin
      failures++; $display("FAIL mem_rst_outs got=%h exp=%h", outs, 16'h0);
    end
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== ov(1,0,0,1,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL mem_rst_fetch got=%h exp=%h", outs, ov(1,0,0,1,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0]     e [4];
    logic [XLEN-1:0] exp_cyc, exp_ret;
    e = '{ov(1,0,0,1,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,1,0,0,0,0),
          ov(0,0,0,0,1,0,0,0,1,0,0)};
    do_reset(32'h0050_0093);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (outs !== e[c % 4]) begin
        failures++; $display("FAIL b2b cyc%0d got=%h exp=%h", c + 1, outs, e[c % 4]);
      end
      tick;
    end
`ifdef PERF_CNT_EN
    exp_cyc = XLEN'(12); exp_ret = XLEN'(3);
`else
    exp_cyc = '0; exp_ret = '0;
`endif
    @(negedge clk);
    checks++;
    if (Cycle_cnt_o !== exp_cyc) begin
      failures++; $display("FAIL cycle_cnt got=%0d exp=%0d", Cycle_cnt_o, exp_cyc);
    end
    checks++;
    if (Retire_cnt_o !== exp_ret) begin
      failures++; $display("FAIL retire_cnt got=%0d exp=%0d", Retire_cnt_o, exp_ret);
    end
  endtask

  initial begin
    test_reset;
    test_fetch_stall;
    test_alu;
    test_load_stall;
    test_store;
    test_branch;
    test_jump;
    test_trap;
    test_reset_in_mem;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
